// File: rtl/rif_reg_bank_pkg.sv
// rif_reg_bank_pkg
//   Shared definitions for the RIF register bank: register byte offsets,
//   default ID constant, the register-select enum and the address decoder
//   used for both the write and the read address paths.
package rif_reg_bank_pkg;

  localparam logic [31:0] ID_VALUE_DEFAULT = 32'h5249_4601;

  localparam logic [31:0] OFS_ID         = 32'h000;
  localparam logic [31:0] OFS_SCRATCH    = 32'h004;
  localparam logic [31:0] OFS_IRQ_STATUS = 32'h008;
  localparam logic [31:0] OFS_IRQ_ENABLE = 32'h00C;
  localparam logic [31:0] OFS_EVT_COUNT  = 32'h010;
  localparam logic [31:0] OFS_CTRL_BASE  = 32'h020;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_ID,
    SEL_SCRATCH,
    SEL_IRQ_STATUS,
    SEL_IRQ_ENABLE,
    SEL_EVT_COUNT,
    SEL_CTRL
  } reg_sel_e;

  typedef struct packed {
    reg_sel_e   sel;
    logic [2:0] idx;  // CTRL word index, meaningful only for SEL_CTRL
  } reg_dec_t;

  // Full-width compare against the map; any misaligned address is unmapped.
  function automatic reg_dec_t decode_addr(input logic [31:0] addr,
                                           input int unsigned num_ctrl);
    reg_dec_t    d;
    logic [31:0] ofs;
    d.sel = SEL_NONE;
    d.idx = '0;
    ofs   = addr - OFS_CTRL_BASE;
    if (addr[1:0] != 2'b00)                d.sel = SEL_NONE;
    else if (addr == OFS_ID)               d.sel = SEL_ID;
    else if (addr == OFS_SCRATCH)          d.sel = SEL_SCRATCH;
    else if (addr == OFS_IRQ_STATUS)       d.sel = SEL_IRQ_STATUS;
    else if (addr == OFS_IRQ_ENABLE)       d.sel = SEL_IRQ_ENABLE;
    else if (addr == OFS_EVT_COUNT)        d.sel = SEL_EVT_COUNT;
    else if (addr >= OFS_CTRL_BASE && ofs < (num_ctrl << 2)) begin
      d.sel = SEL_CTRL;
      d.idx = ofs[4:2];
    end
    return d;
  endfunction

endpackage

// File: rtl/rif_reg_bank_if.sv
// rif_reg_bank_if
//   RIF write/read channel between the AXI4-Lite adapter (master) and the
//   register bank (slave).
//   Write: rif_waddr, rif_wr_req, rif_wstrb, rif_wdata -> rif_wvalid
//   Read : rif_raddr, rif_rd_req                       -> rif_rdata, rif_rvalid
interface rif_reg_bank_if
  import rif_reg_bank_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_COUNT = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0] rif_waddr;
  logic                  rif_wr_req;
  logic [BYTE_COUNT-1:0] rif_wstrb;
  logic [DATA_WIDTH-1:0] rif_wdata;
  logic                  rif_wvalid;
  logic [ADDR_WIDTH-1:0] rif_raddr;
  logic                  rif_rd_req;
  logic [DATA_WIDTH-1:0] rif_rdata;
  logic                  rif_rvalid;

  modport master (
    output rif_waddr, rif_wr_req, rif_wstrb, rif_wdata, rif_raddr, rif_rd_req,
    input  rif_wvalid, rif_rdata, rif_rvalid
  );

  modport slave (
    input  rif_waddr, rif_wr_req, rif_wstrb, rif_wdata, rif_raddr, rif_rd_req,
    output rif_wvalid, rif_rdata, rif_rvalid
  );
endinterface

// File: rtl/rif_strb_reg.sv
// rif_strb_reg
//   One DATA_WIDTH register with per-byte write strobes.
//   aclk/aresetn : clock, async active-low reset (clears to 0)
//   we           : write enable (already qualified by decode)
//   wstrb/wdata  : byte enables and write data
//   q            : register contents; bits outside IMPL_MASK always read 0
module rif_strb_reg
  import rif_reg_bank_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    BYTE_COUNT = DATA_WIDTH / 8,
  parameter logic [DATA_WIDTH-1:0] IMPL_MASK  = '1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  we,
  input  logic [BYTE_COUNT-1:0] wstrb,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] q
);
  logic [DATA_WIDTH-1:0] merged;

  always_comb begin
    merged = q;
    for (int k = 0; k < BYTE_COUNT; k++) begin
      if (wstrb[k]) merged[8*k +: 8] = wdata[8*k +: 8];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)  q <= '0;
    else if (we)   q <= merged & IMPL_MASK;
  end
endmodule

// File: rtl/rif_reg_bank.sv
// rif_reg_bank
//   Control/status register bank behind the AXI4-Lite-to-RIF adapter.
//   aclk, aresetn : clock, async active-low reset
//   rif           : RIF slave channel (byte-strobed writes, zero-latency reads,
//                   combinational rif_wvalid/rif_rvalid decode flags)
//   irq_event     : per-line event pulses that set IRQ_STATUS bits
//   ctrl          : NUM_CTRL control words, CTRL[i] at [32i+31:32i]
//   irq           : registered |(IRQ_STATUS & IRQ_ENABLE)
module rif_reg_bank
  import rif_reg_bank_pkg::*;
#(
  parameter int          ADDR_WIDTH = 12,
  parameter int          DATA_WIDTH = 32,
  parameter int          BYTE_COUNT = DATA_WIDTH / 8,
  parameter int          NUM_CTRL   = 4,
  parameter int          IRQ_WIDTH  = 8,
  parameter logic [31:0] ID_VALUE   = ID_VALUE_DEFAULT
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  rif_reg_bank_if.slave                  rif,
  input  logic [IRQ_WIDTH-1:0]           irq_event,
  output logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl,
  output logic                           irq
);
  localparam logic [DATA_WIDTH-1:0] IRQ_MASK =
    DATA_WIDTH'((64'd1 << IRQ_WIDTH) - 64'd1);

  reg_dec_t dec_w, dec_r;
  logic     wr_fire;

  logic [DATA_WIDTH-1:0] scratch_q, irq_en_q, evt_cnt_q;
  logic [IRQ_WIDTH-1:0]  irq_status_q, w1c_mask;
  logic [DATA_WIDTH-1:0] ctrl_q [NUM_CTRL];
  logic                  evt_any, evt_rd_clr;

  assign dec_w = decode_addr(32'(rif.rif_waddr[ADDR_WIDTH-1:0]), NUM_CTRL);
  assign dec_r = decode_addr(32'(rif.rif_raddr[ADDR_WIDTH-1:0]), NUM_CTRL);

  // ID and EVT_COUNT are mapped for reads but reject writes.
  assign rif.rif_wvalid = (dec_w.sel == SEL_SCRATCH)    ||
                          (dec_w.sel == SEL_IRQ_STATUS) ||
                          (dec_w.sel == SEL_IRQ_ENABLE) ||
                          (dec_w.sel == SEL_CTRL);
  assign wr_fire = rif.rif_wr_req && rif.rif_wvalid;

  rif_strb_reg #(.DATA_WIDTH(DATA_WIDTH), .BYTE_COUNT(BYTE_COUNT)) u_scratch (
    .aclk(aclk), .aresetn(aresetn),
    .we(wr_fire && dec_w.sel == SEL_SCRATCH),
    .wstrb(rif.rif_wstrb), .wdata(rif.rif_wdata), .q(scratch_q)
  );

  rif_strb_reg #(.DATA_WIDTH(DATA_WIDTH), .BYTE_COUNT(BYTE_COUNT),
                 .IMPL_MASK(IRQ_MASK)) u_irq_en (
    .aclk(aclk), .aresetn(aresetn),
    .we(wr_fire && dec_w.sel == SEL_IRQ_ENABLE),
    .wstrb(rif.rif_wstrb), .wdata(rif.rif_wdata), .q(irq_en_q)
  );

  for (genvar i = 0; i < NUM_CTRL; i++) begin : g_ctrl
    rif_strb_reg #(.DATA_WIDTH(DATA_WIDTH), .BYTE_COUNT(BYTE_COUNT)) u_ctrl (
      .aclk(aclk), .aresetn(aresetn),
      .we(wr_fire && dec_w.sel == SEL_CTRL && dec_w.idx == 3'(i)),
      .wstrb(rif.rif_wstrb), .wdata(rif.rif_wdata), .q(ctrl_q[i])
    );
    assign ctrl[i*DATA_WIDTH +: DATA_WIDTH] = ctrl_q[i];
  end

  // W1C mask: a status bit clears only if its byte lane is strobed.
  always_comb begin
    w1c_mask = '0;
    if (wr_fire && dec_w.sel == SEL_IRQ_STATUS) begin
      for (int n = 0; n < IRQ_WIDTH; n++) begin
        w1c_mask[n] = rif.rif_wdata[n] & rif.rif_wstrb[n/8];
      end
    end
  end

  // Events are OR-ed in after the clear so a same-edge event wins.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) irq_status_q <= '0;
    else          irq_status_q <= (irq_status_q & ~w1c_mask) | irq_event;
  end

  assign evt_any    = |irq_event;
  assign evt_rd_clr = rif.rif_rd_req && dec_r.sel == SEL_EVT_COUNT;

  // Clear-on-read takes the pre-clear value to rdata; a coincident event
  // leaves the count at 1 rather than 0.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                         evt_cnt_q <= '0;
    else if (evt_rd_clr)                  evt_cnt_q <= DATA_WIDTH'(evt_any);
    else if (evt_any && evt_cnt_q != '1)  evt_cnt_q <= evt_cnt_q + 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) irq <= 1'b0;
    else          irq <= |(DATA_WIDTH'(irq_status_q) & irq_en_q);
  end

  always_comb begin
    rif.rif_rdata  = '0;
    rif.rif_rvalid = 1'b1;
    case (dec_r.sel)
      SEL_ID:         rif.rif_rdata = DATA_WIDTH'(ID_VALUE);
      SEL_SCRATCH:    rif.rif_rdata = scratch_q;
      SEL_IRQ_STATUS: rif.rif_rdata = DATA_WIDTH'(irq_status_q);
      SEL_IRQ_ENABLE: rif.rif_rdata = irq_en_q;
      SEL_EVT_COUNT:  rif.rif_rdata = evt_cnt_q;
      SEL_CTRL: begin
        for (int i = 0; i < NUM_CTRL; i++) begin
          if (dec_r.idx == 3'(i)) rif.rif_rdata = ctrl_q[i];
        end
      end
      default:        rif.rif_rvalid = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_rif_reg_bank.sv
// tb_rif_reg_bank
//   Randomized + directed bench with a behavioural register-map model.
//   Stimulus pushes expected read/write/output responses into queues; a
//   negedge monitor pops and compares them.
module tb_rif_reg_bank;
  localparam int          AW   = 12;
  localparam int          DW   = 32;
  localparam int          NC   = 4;
  localparam int          IW   = 8;
  localparam logic [31:0] IDV  = 32'h5249_4601;
  localparam logic [31:0] IMSK = 32'h0000_00FF;

  logic           aclk = 1'b0;
  logic           aresetn = 1'b0;
  logic [IW-1:0]  irq_event;
  logic [NC*DW-1:0] ctrl;
  logic           irq;

  rif_reg_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  rif_reg_bank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CTRL(NC),
                 .IRQ_WIDTH(IW)) dut (
    .aclk(aclk), .aresetn(aresetn), .rif(bus),
    .irq_event(irq_event), .ctrl(ctrl), .irq(irq)
  );

  always #5 aclk = ~aclk;

  typedef struct { logic [11:0] a; logic v; logic [31:0] d; } rd_exp_t;
  typedef struct { logic [11:0] a; logic v; } wr_exp_t;
  typedef struct { logic [NC*DW-1:0] c; logic i; } obs_exp_t;

  rd_exp_t  rd_q[$];
  wr_exp_t  wr_q[$];
  obs_exp_t obs_q[$];
  rd_exp_t  re;
  wr_exp_t  we_e;
  obs_exp_t oe;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  // ---------------- reference model ----------------
  logic [31:0] m_scratch, m_stat, m_en, m_cnt;
  logic [31:0] m_ctrl [NC];
  logic        m_irq;

  task automatic model_reset();
    m_scratch = 0; m_stat = 0; m_en = 0; m_cnt = 0; m_irq = 0;
    for (int i = 0; i < NC; i++) m_ctrl[i] = 0;
  endtask

  function automatic bit is_ctrl(input logic [11:0] a);
    return (a % 4 == 0) && (int'(a) >= 32) && (int'(a) < 32 + 4*NC);
  endfunction

  function automatic logic model_wvalid(input logic [11:0] a);
    return (a == 12'h004) || (a == 12'h008) || (a == 12'h00C) || is_ctrl(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int k = 0; k < 4; k++) if (s[k]) r[8*k +: 8] = n[8*k +: 8];
    return r;
  endfunction

  task automatic model_read(input logic [11:0] a, output logic v, output logic [31:0] d);
    v = 1'b1; d = 32'h0;
    if      (a == 12'h000) d = IDV;
    else if (a == 12'h004) d = m_scratch;
    else if (a == 12'h008) d = m_stat;
    else if (a == 12'h00C) d = m_en;
    else if (a == 12'h010) d = m_cnt;
    else if (is_ctrl(a))   d = m_ctrl[(int'(a) - 32) / 4];
    else                   v = 1'b0;
  endtask

  function automatic logic [NC*DW-1:0] model_ctrl_flat();
    logic [NC*DW-1:0] f;
    for (int i = 0; i < NC; i++) f[32*i +: 32] = m_ctrl[i];
    return f;
  endfunction

  task automatic model_step(input bit wr, input logic [11:0] wa, input logic [3:0] ws,
                            input logic [31:0] wd, input bit rd, input logic [11:0] ra,
                            input logic [7:0] ev);
    logic n_irq;
    n_irq = |(m_stat & m_en);
    if (wr && model_wvalid(wa)) begin
      if (wa == 12'h004) m_scratch = merge(m_scratch, wd, ws);
      else if (wa == 12'h008) begin
        for (int k = 0; k < 4; k++) if (ws[k]) m_stat[8*k +: 8] = m_stat[8*k +: 8] & ~wd[8*k +: 8];
      end
      else if (wa == 12'h00C) m_en = merge(m_en, wd, ws) & IMSK;
      else m_ctrl[(int'(wa) - 32) / 4] = merge(m_ctrl[(int'(wa) - 32) / 4], wd, ws);
    end
    m_stat = (m_stat | 32'(ev)) & IMSK;
    if (rd && ra == 12'h010)                  m_cnt = (ev != 0) ? 32'd1 : 32'd0;
    else if (ev != 0 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    m_irq = n_irq;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // One clock: drive at posedge+1, queue expectations, advance the model.
  task automatic cycle(input bit wr, input logic [11:0] wa, input logic [3:0] ws,
                       input logic [31:0] wd, input bit rd, input logic [11:0] ra,
                       input logic [7:0] ev);
    rd_exp_t  r;
    wr_exp_t  w;
    obs_exp_t o;
    bus.rif_wr_req = wr; bus.rif_waddr = wa; bus.rif_wstrb = ws; bus.rif_wdata = wd;
    bus.rif_rd_req = rd; bus.rif_raddr = ra; irq_event = ev;
    if (rd) begin
      model_read(ra, r.v, r.d);
      r.a = ra;
      rd_q.push_back(r);
    end
    if (wr) begin
      w.a = wa; w.v = model_wvalid(wa);
      wr_q.push_back(w);
    end
    o.c = model_ctrl_flat(); o.i = m_irq;
    obs_q.push_back(o);
    model_step(wr, wa, ws, wd, rd, ra, ev);
    @(posedge aclk); #1;
  endtask

  task automatic idle();
    cycle(0, 12'h0, 4'h0, 32'h0, 0, 12'h0, 8'h0);
  endtask

  task automatic wr1(input logic [11:0] a, input logic [3:0] s, input logic [31:0] d,
                     input logic [7:0] ev);
    cycle(1, a, s, d, 0, 12'h0, ev);
  endtask

  task automatic rd1(input logic [11:0] a, input logic [7:0] ev);
    cycle(0, 12'h0, 4'h0, 32'h0, 1, a, ev);
  endtask

  // ---------------- monitor ----------------
  always @(negedge aclk) begin
    if (mon_en) begin
      if (bus.rif_rd_req) begin
        checks++;
        if (rd_q.size() == 0) begin
          failures++;
          $display("FAIL rd_unexpected addr=%h", bus.rif_raddr);
        end else begin
          re = rd_q.pop_front();
          if (bus.rif_rvalid !== re.v || bus.rif_rdata !== re.d) begin
            failures++;
            $display("FAIL rd addr=%h got v=%b d=%h expected v=%b d=%h",
                     re.a, bus.rif_rvalid, bus.rif_rdata, re.v, re.d);
          end
        end
      end
      if (bus.rif_wr_req) begin
        checks++;
        if (wr_q.size() == 0) begin
          failures++;
          $display("FAIL wr_unexpected addr=%h", bus.rif_waddr);
        end else begin
          we_e = wr_q.pop_front();
          if (bus.rif_wvalid !== we_e.v) begin
            failures++;
            $display("FAIL wvalid addr=%h got=%b expected=%b", we_e.a, bus.rif_wvalid, we_e.v);
          end
        end
      end
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL obs_missing");
      end else begin
        oe = obs_q.pop_front();
        if (ctrl !== oe.c || irq !== oe.i) begin
          failures++;
          $display("FAIL outputs got ctrl=%h irq=%b expected ctrl=%h irq=%b",
                   ctrl, irq, oe.c, oe.i);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  logic [11:0] addrs [15] = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014,
                              12'h020, 12'h024, 12'h028, 12'h02C, 12'h030, 12'h006,
                              12'h022, 12'h100, 12'hFFC};

  initial begin
    bus.rif_wr_req = 0; bus.rif_waddr = 0; bus.rif_wstrb = 0; bus.rif_wdata = 0;
    bus.rif_rd_req = 0; bus.rif_raddr = 0; irq_event = 0;
    model_reset();
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_ctrl", 64'(ctrl[63:0]), 64'h0);
    chk("rst_irq", 64'(irq), 64'h0);
    aresetn = 1'b1;
    mon_en  = 1'b1;

    // reset-state reads
    rd1(12'h000, 0);
    rd1(12'h004, 0);
    rd1(12'h010, 0);

    // byte-strobed CTRL write and read-back
    wr1(12'h020, 4'b0101, 32'hAABB_CCDD, 0);
    chk("ctrl0_strb", 64'(ctrl[31:0]), 64'h00BB_00DD);
    rd1(12'h020, 0);

    // rejected writes and bad reads
    wr1(12'h000, 4'hF, 32'hFFFF_FFFF, 0);
    wr1(12'h100, 4'hF, 32'hFFFF_FFFF, 0);
    wr1(12'h010, 4'hF, 32'hFFFF_FFFF, 0);
    wr1(12'h022, 4'hF, 32'hFFFF_FFFF, 0);
    rd1(12'h006, 0);
    rd1(12'h100, 0);
    rd1(12'h000, 0);
    rd1(12'h020, 0);

    // interrupt path
    wr1(12'h00C, 4'h1, 32'h0000_0008, 0);
    idle();
    cycle(0, 12'h0, 4'h0, 32'h0, 0, 12'h0, 8'h08);
    rd1(12'h008, 0);
    chk("irq_set", 64'(irq), 64'h1);
    wr1(12'h008, 4'h1, 32'h0000_0008, 8'h08);   // set wins over W1C
    rd1(12'h008, 0);
    wr1(12'h008, 4'h1, 32'h0000_0008, 0);
    rd1(12'h008, 0);
    chk("irq_drop", 64'(irq), 64'h0);
    idle();

    // event counter: clear, count three, clear-on-read, read vs event
    rd1(12'h010, 0);
    idle();
    repeat (3) cycle(0, 12'h0, 4'h0, 32'h0, 0, 12'h0, 8'h01);
    rd1(12'h010, 0);
    rd1(12'h010, 0);
    rd1(12'h010, 8'h10);
    rd1(12'h010, 0);

    // same-register read and write in one cycle
    cycle(1, 12'h004, 4'hF, 32'h1234_5678, 1, 12'h004, 0);
    cycle(1, 12'h004, 4'h2, 32'hFFFF_FFFF, 1, 12'h004, 0);
    rd1(12'h004, 0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [11:0] wa, ra;
      logic [7:0]  ev;
      wa = ($urandom_range(0, 7) == 0) ? 12'($urandom) : addrs[$urandom_range(0, 14)];
      ra = ($urandom_range(0, 7) == 0) ? 12'($urandom) : addrs[$urandom_range(0, 14)];
      ev = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      cycle(1'($urandom), wa, 4'($urandom), $urandom, 1'($urandom), ra, ev);
    end

    // asynchronous reset with CTRL and irq set
    wr1(12'h024, 4'hF, 32'h1234_5678, 0);
    wr1(12'h00C, 4'h1, 32'h0000_00FF, 8'h01);
    idle();
    idle();
    chk("pre_rst_irq", 64'(irq), 64'h1);
    chk("pre_rst_ctrl1", 64'(ctrl[63:32]), 64'h1234_5678);
    mon_en = 1'b0;
    bus.rif_raddr = 12'h024;
    #2 aresetn = 1'b0;
    #1;
    chk("async_rst_ctrl", 64'(ctrl[63:0]), 64'h0);
    chk("async_rst_irq", 64'(irq), 64'h0);
    chk("async_rst_rdata", 64'(bus.rif_rdata), 64'h0);
    model_reset();
    @(posedge aclk); #1;
    aresetn = 1'b1;
    mon_en  = 1'b1;
    rd1(12'h024, 0);
    rd1(12'h008, 0);
    rd1(12'h00C, 0);
    for (int n = 0; n < 50; n++) begin
      cycle(1'($urandom), addrs[$urandom_range(0, 14)], 4'($urandom), $urandom,
            1'($urandom), addrs[$urandom_range(0, 14)],
            ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
    end
    idle();
    mon_en = 1'b0;

    chk("rd_q_drain", 64'(rd_q.size()), 64'h0);
    chk("wr_q_drain", 64'(wr_q.size()), 64'h0);
    chk("obs_q_drain", 64'(obs_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
